regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port register file with an integrated busy-bit scoreboard.
//  Successor to the 32x32 2R1W file: configurable width, depth and port counts.
//  Adds write-to-read bypass, a hardwired zero register and per-register pending-write tracking.
//  Sits in the decode stage of the pipelined core; issue logic uses rd_busy to stall on RAW hazards.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register index width; DEPTH = 2**ADDR_W
//  NUM_RD    2   number of read ports
//  NUM_WR    2   number of write ports; higher index has priority
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never busy
//  BYPASS    1   1: reads return same-cycle write data; 0: reads return stored value
// PORTS
//  clk       in   1               rising-edge clock
//  rst       in   1               asynchronous reset, active-low (0 = reset)
//  rd_addr   in   NUM_RD*ADDR_W   packed read indices, port k at [k*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W   packed read data, combinational
//  rd_busy   out  NUM_RD          1 = indexed register has an outstanding write
//  wr_en     in   NUM_WR          per-port write enable
//  wr_addr   in   NUM_WR*ADDR_W   packed write indices
//  wr_data   in   NUM_WR*DATA_W   packed write data
//  iss_en    in   1               issue: mark iss_addr as pending-write
//  iss_addr  in   ADDR_W          destination register of issued instruction
//  busy_vec  out  DEPTH           registered busy bit per register
// BEHAVIOUR
//  - Reset (rst=0, async): all registers 0, busy_vec 0. Outputs are combinational from state,
//    so rd_data and rd_busy read 0 during reset. Reset mid-operation drops all pending writes.
//  - Write: on posedge clk, each wr_en[p] stores wr_data[p] to wr_addr[p]. Same-address
//    collision in one cycle: the highest-index enabled port wins.
//  - ZERO_REG=1: writes and issues to index 0 are ignored; rd_data for index 0 = 0; busy[0]=0.
//  - Read: zero-cycle latency. BYPASS=1: if any enabled write port hits rd_addr this cycle,
//    rd_data = that port's wr_data (highest-index hit wins), else stored value. BYPASS=0: stored value.
//  - Scoreboard next state, per register r:
//    busy[r] <= (busy[r] & ~clr[r]) | set[r];
//    clr[r] = any wr_en to r; set[r] = iss_en & iss_addr==r.
//    Issue and writeback to the same r in one cycle: busy stays 1 (new producer wins).
//  - rd_busy[k] = busy[rd_addr[k]] & ~(BYPASS & write hit on rd_addr[k] this cycle).
//  - Write to a non-busy register is legal; it simply stores, and busy stays 0.
//  - Out-of-range indices cannot occur (DEPTH = 2**ADDR_W). No X is propagated from unused ports.
// STRUCTURE
//  - Package regfile_pkg: default DATA_W/ADDR_W localparams and a function
//    wr_hit(addr, wr_en, wr_addr) returning the winning port index and a hit flag.
//    The same function drives both storage priority and bypass selection.
//  - Sub-module regfile_scoreboard: busy_vec flops, set/clear logic, ZERO_REG masking.
//  - Top: storage array, write-priority loop, read/bypass muxes, rd_busy masking.
// TESTING
//  1 Reset: rst=0 then 1; read all 32 indices -> rd_data=0, busy_vec=0.
//  2 Write/read: wr_en[0]=1, addr 5, data 6; next cycle read port0 addr 5 -> 6.
//    Same-cycle read with BYPASS=1 -> 6; with BYPASS=0 -> 0.
//  3 Collision: ports 0,1 both write addr 7 (0xAAAA, 0x5555) -> reg7=0x5555.
//    Bypass read of 7 in that cycle -> 0x5555.
//  4 Zero reg: write 0xFFFF to addr 0 and iss_en addr 0 -> rd_data=0, busy_vec[0]=0.
//  5 Scoreboard: iss addr 9 -> busy_vec[9]=1 and rd_busy=1 next cycle.
//    Write addr 9 plus iss addr 9 in the same cycle -> busy stays 1.
//    Write alone -> busy clears. Bypass-cycle rd_busy=0.
//  6 Async reset mid-op: busy_vec[3]=1, reg3=0x1234; drop rst between edges
//    -> immediate rd_data=0, busy_vec=0.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// rtl/regfile_mp_sb_pkg.sv - shared defaults, write-hit record and the write-port priority function
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int MAX_WR     = 8;
    localparam int MAX_ADDR_W = 16;
    localparam int WR_IDX_W   = 3;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] port;
    } wr_hit_t;

    // Ports are scanned low to high so the highest-index enabled hit is the one left standing.
    function automatic wr_hit_t wr_hit(
        input logic [MAX_ADDR_W-1:0]        addr,
        input logic [MAX_WR-1:0]            wr_en,
        input logic [MAX_WR*MAX_ADDR_W-1:0] wr_addr
    );
        wr_hit_t res;
        res = '0;
        for (int p = 0; p < MAX_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*MAX_ADDR_W +: MAX_ADDR_W] == addr)) begin
                res.hit  = 1'b1;
                res.port = WR_IDX_W'(p);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// rtl/regfile_mp_sb_if.sv - read, write, issue and scoreboard bus of the register file
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int DEPTH = 2**ADDR_W;

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [DEPTH-1:0]         busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// rtl/regfile_mp_sb_scoreboard.sv - per-register pending-write busy bits
module regfile_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] clr;
    logic [DEPTH-1:0] set;

    always_comb begin
        clr = '0;
        set = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                clr[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        if (iss_en) begin
            set[iss_addr] = 1'b1;
        end
        // Set is applied after clear so a new producer issued alongside a writeback keeps the bit.
        busy_d = (busy_q & ~clr) | set;
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass, zero register and busy scoreboard
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]            mem_q [DEPTH];
    logic [DATA_W-1:0]            mem_d [DEPTH];
    logic [MAX_WR-1:0]            wr_en_pad;
    logic [MAX_WR*MAX_ADDR_W-1:0] wr_addr_pad;
    logic [DEPTH-1:0]             busy_vec;
    logic [NUM_RD*DATA_W-1:0]     rd_data;
    logic [NUM_RD-1:0]            rd_busy;

    // Write ports are widened to the package maxima so one priority function serves any configuration.
    always_comb begin
        wr_en_pad   = '0;
        wr_addr_pad = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_en_pad[p] = bus.wr_en[p];
            wr_addr_pad[p*MAX_ADDR_W +: MAX_ADDR_W] = MAX_ADDR_W'(bus.wr_addr[p*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        wr_hit_t h;
        h = '0;
        for (int r = 0; r < DEPTH; r++) begin
            mem_d[r] = mem_q[r];
            h = wr_hit(MAX_ADDR_W'(r), wr_en_pad, wr_addr_pad);
            if (h.hit && !(ZERO_REG != 0 && r == 0)) begin
                mem_d[r] = bus.wr_data[int'(h.port)*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .busy_vec (busy_vec)
    );

    // A bypassed read already carries the producer's result, so it is not reported busy.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        wr_hit_t           h;
        logic              byp;
        rd_data = '0;
        rd_busy = '0;
        a   = '0;
        d   = '0;
        h   = '0;
        byp = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            a   = bus.rd_addr[k*ADDR_W +: ADDR_W];
            h   = wr_hit(MAX_ADDR_W'(a), wr_en_pad, wr_addr_pad);
            byp = (BYPASS != 0) && h.hit;
            d   = byp ? bus.wr_data[int'(h.port)*DATA_W +: DATA_W] : mem_q[a];
            if (ZERO_REG != 0 && a == '0) begin
                d = '0;
            end
            rd_data[k*DATA_W +: DATA_W] = d;
            rd_busy[k] = busy_vec[a] & ~byp;
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed vector bench for regfile_mp_sb (bypass and no-bypass instances)
module tb_regfile_mp_sb;

    logic clk;
    logic rst;

    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bif ();
    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) nbif ();

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
        u_dut (.clk(clk), .rst(rst), .bus(bif));

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0))
        u_dut_nb (.clk(clk), .rst(rst), .bus(nbif));

    assign nbif.rd_addr  = bif.rd_addr;
    assign nbif.wr_en    = bif.wr_en;
    assign nbif.wr_addr  = bif.wr_addr;
    assign nbif.wr_data  = bif.wr_data;
    assign nbif.iss_en   = bif.iss_en;
    assign nbif.iss_addr = bif.iss_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [1:0]  exp_busy;
        logic [31:0] exp_bv;
        logic [31:0] exp_nb_rd0;
    } vec_t;

    vec_t vecs [13];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bif.wr_en    = '0;
        bif.wr_addr  = '0;
        bif.wr_data  = '0;
        bif.iss_en   = 1'b0;
        bif.iss_addr = '0;
        bif.rd_addr  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //        we     wa0 wa1 wd0           wd1           ie    ia  ra0 ra1 rd0           rd1           busy   bv            nb_rd0
        vecs[0]  = '{2'b01, 5, 0, 32'h6,        32'h0,        1'b0, 0,  5,  5,  32'h6,        32'h6,        2'b00, 32'h0,        32'h0};
        vecs[1]  = '{2'b00, 0, 0, 32'h0,        32'h0,        1'b0, 0,  5,  0,  32'h6,        32'h0,        2'b00, 32'h0,        32'h6};
        vecs[2]  = '{2'b11, 7, 7, 32'hAAAA,     32'h5555,     1'b0, 0,  7,  5,  32'h5555,     32'h6,        2'b00, 32'h0,        32'h0};
        vecs[3]  = '{2'b00, 0, 0, 32'h0,        32'h0,        1'b0, 0,  7,  7,  32'h5555,     32'h5555,     2'b00, 32'h0,        32'h5555};
        vecs[4]  = '{2'b01, 0, 0, 32'hFFFF,     32'h0,        1'b1, 0,  0,  7,  32'h0,        32'h5555,     2'b00, 32'h0,        32'h0};
        vecs[5]  = '{2'b00, 0, 0, 32'h0,        32'h0,        1'b1, 9,  0,  9,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0};
        vecs[6]  = '{2'b00, 0, 0, 32'h0,        32'h0,        1'b0, 0,  9,  9,  32'h0,        32'h0,        2'b11, 32'h200,      32'h0};
        vecs[7]  = '{2'b10, 0, 9, 32'h0,        32'h99,       1'b1, 9,  9,  7,  32'h99,       32'h5555,     2'b00, 32'h200,      32'h0};
        vecs[8]  = '{2'b00, 0, 0, 32'h0,        32'h0,        1'b0, 0,  9,  9,  32'h99,       32'h99,       2'b11, 32'h200,      32'h99};
        vecs[9]  = '{2'b01, 9, 0, 32'h42,       32'h0,        1'b0, 0,  9,  5,  32'h42,       32'h6,        2'b00, 32'h200,      32'h99};
        vecs[10] = '{2'b00, 0, 0, 32'h0,        32'h0,        1'b0, 0,  9,  9,  32'h42,       32'h42,       2'b00, 32'h0,        32'h42};
        vecs[11] = '{2'b01, 3, 0, 32'h1234,     32'h0,        1'b1, 3,  3,  9,  32'h1234,     32'h42,       2'b00, 32'h0,        32'h0};
        vecs[12] = '{2'b00, 0, 0, 32'h0,        32'h0,        1'b0, 0,  3,  0,  32'h1234,     32'h0,        2'b01, 32'h8,        32'h1234};

        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            bif.rd_addr = {5'd0, 5'(i)};
            #1;
            check($sformatf("reset_rd%0d", i), bif.rd_data[31:0], 32'h0);
        end
        check("reset_busy_vec", bif.busy_vec, 32'h0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bif.wr_en    = vecs[i].we;
            bif.wr_addr  = {vecs[i].wa1, vecs[i].wa0};
            bif.wr_data  = {vecs[i].wd1, vecs[i].wd0};
            bif.iss_en   = vecs[i].ie;
            bif.iss_addr = vecs[i].ia;
            bif.rd_addr  = {vecs[i].ra1, vecs[i].ra0};
            #1;
            check($sformatf("v%0d_rd0", i), bif.rd_data[31:0], vecs[i].exp_rd0);
            check($sformatf("v%0d_rd1", i), bif.rd_data[63:32], vecs[i].exp_rd1);
            check($sformatf("v%0d_rd_busy", i), 32'(bif.rd_busy), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d_busy_vec", i), bif.busy_vec, vecs[i].exp_bv);
            check($sformatf("v%0d_nobypass_rd0", i), nbif.rd_data[31:0], vecs[i].exp_nb_rd0);
        end

        // Reset dropped between edges must clear state immediately.
        @(negedge clk);
        drive_idle();
        bif.rd_addr = {5'd9, 5'd3};
        #1;
        check("pre_async_rd0", bif.rd_data[31:0], 32'h1234);
        check("pre_async_busy_vec", bif.busy_vec, 32'h8);
        #1;
        rst = 1'b0;
        #1;
        check("async_rd0", bif.rd_data[31:0], 32'h0);
        check("async_rd1", bif.rd_data[63:32], 32'h0);
        check("async_busy_vec", bif.busy_vec, 32'h0);
        check("async_rd_busy", 32'(bif.rd_busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_rd0", bif.rd_data[31:0], 32'h0);
        check("post_reset_busy_vec", bif.busy_vec, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
